// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch/sequencing stage. Reads the instruction at the current
//               PC from a writable program memory, hands it to execute over a
//               valid/ready handshake and pulses the PC enable to advance.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int                ADDR_W  = 4,
    parameter int                DATA_W  = 8,
    parameter int                DEPTH   = 16,
    parameter logic [DATA_W-1:0] HALT_OP = 8'hFF,
    parameter logic [DATA_W-1:0] JMP0_OP = 8'h01
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              prog_we_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [DATA_W-1:0] prog_data_i,
    input  logic              ex_ready_i,
    output logic [DATA_W-1:0] ir_o,
    output logic              ir_valid_o,
    output logic              pc_en_o,
    output logic              halted_o,
    output logic [7:0]        instr_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_WAIT_EX = 3'd3,
        S_ADVANCE = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_ir;
    logic              r_ir_valid;
    logic              r_pc_en;
    logic              r_halted;
    logic [7:0]        r_cnt;
    logic              w_is_halt;
    logic              w_xfer;

    // An aliased HALT/JMP0 encoding is treated as a jump, never a stop.
    assign w_is_halt = (r_rd_data == HALT_OP) && (HALT_OP != JMP0_OP);
    assign w_xfer    = (r_state == S_WAIT_EX) && ex_ready_i;

    // Program memory: not reset; read-before-write on a same-address collision.
    always_ff @(posedge clk_i) begin
        if (prog_we_i) begin
            r_mem[prog_addr_i] <= prog_data_i;
        end
        if (r_state == S_FETCH) begin
            r_rd_data <= r_mem[pc_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (run_i) w_state_nxt = S_FETCH;
            S_FETCH:   w_state_nxt = S_DECODE;
            S_DECODE:  w_state_nxt = w_is_halt ? S_HALT : S_WAIT_EX;
            S_WAIT_EX: if (ex_ready_i) w_state_nxt = S_ADVANCE;
            S_ADVANCE: w_state_nxt = run_i ? S_FETCH : S_IDLE;
            S_HALT:    w_state_nxt = S_HALT;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // pc_en comes straight from a flop because it clocks the PC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_pc_en    <= 1'b0;
            r_halted   <= 1'b0;
            r_cnt      <= 8'd0;
        end else begin
            r_pc_en <= w_xfer;
            if (r_state == S_DECODE) begin
                r_ir <= r_rd_data;
                if (w_is_halt) begin
                    r_halted <= 1'b1;
                end else begin
                    r_ir_valid <= 1'b1;
                end
            end
            if (w_xfer) begin
                r_ir_valid <= 1'b0;
                r_cnt      <= r_cnt + 8'd1;
            end
        end
    end

    assign ir_o        = r_ir;
    assign ir_valid_o  = r_ir_valid;
    assign pc_en_o     = r_pc_en;
    assign halted_o    = r_halted;
    assign instr_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch/sequencing stage that sits directly downstream of the 4-bit program counter, which it also drives.
- Reads the current PC value and fetches the 8-bit instruction from an internal writable 16-entry program memory. It latches that instruction into an instruction register, presents it to execute with a valid/ready handshake, then pulses the PC enable to advance.
- The PC's data input is driven by ir_o, so opcode JMP0_OP causes the PC to return to 0 on the advance pulse.

Parameters:
ADDR_W, 4, program memory address width; matches PC width
DATA_W, 8, instruction width
DEPTH, 16, program memory entries (2**ADDR_W)
HALT_OP, 8'hFF, opcode that stops sequencing
JMP0_OP, 8'h01, opcode the PC interprets as jump-to-zero; passed through, not acted on here

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
run_i  input  1  level; 1 = sequence instructions
pc_i  input  ADDR_W  current PC value
prog_we_i  input  1  program memory write strobe
prog_addr_i  input  ADDR_W  program write address
prog_data_i  input  DATA_W  program write data
ex_ready_i  input  1  execute stage accepts ir_o
ir_o  output  DATA_W  instruction register; also feeds PC data input
ir_valid_o  output  1  ir_o valid for execute
pc_en_o  output  1  registered one-cycle PC advance pulse (PC is edge-triggered on it)
halted_o  output  1  HALT_OP fetched
instr_cnt_o  output  8  completed handshakes, wraps 255->0

Behaviour:
- Reset (rst_ni=0, async): state IDLE; ir_o=8'h00; ir_valid_o=0; pc_en_o=0; halted_o=0; instr_cnt_o=0. Program memory contents are NOT reset. Reset mid-instruction abandons it with no pc_en_o pulse.
- Program memory:
  - Synchronous write when prog_we_i=1, accepted in any state.
  - Synchronous read, 1-cycle latency, address = pc_i sampled in FETCH.
  - Same-cycle write and read of one address returns the old data (read-before-write).
- FSM states IDLE, FETCH, DECODE, WAIT_EX, ADVANCE, HALT:
  - IDLE: all strobes 0. run_i=1 -> FETCH.
  - FETCH: memory read issued at pc_i -> DECODE. run_i is not checked.
  - DECODE: ir_o <= memory data.
    - If data==HALT_OP -> HALT, with halted_o=1 from next cycle and ir_valid_o staying 0.
    - Otherwise ir_valid_o=1 from next cycle -> WAIT_EX.
  - WAIT_EX: ir_valid_o and ir_o held stable until ex_ready_i=1. On ready, the transfer completes that edge: ir_valid_o<=0, instr_cnt_o+=1 -> ADVANCE. No timeout.
  - ADVANCE: pc_en_o=1 for exactly this one cycle, driven from a flop (glitch-free, since it clocks the PC). Next state FETCH if run_i=1, else IDLE. The PC updates during ADVANCE, so the following FETCH samples the new pc_i.
  - HALT: holds halted_o=1 and ir_o; ignores run_i; only reset exits.
- run_i dropped mid-instruction: the current instruction completes through ADVANCE, then IDLE.
- Minimum fetch-to-advance cycle: FETCH, DECODE, WAIT_EX (ready already high), ADVANCE = 4 clocks per instruction.
- ir_o changes only in DECODE; it is stable during ADVANCE so the PC sees the opcode at its enable edge.
- PC wrap 15->0 requires no special handling here.
- pc_en_o never asserts in IDLE, HALT or during reset.

Test Plan:
- Basic sequencing: load mem[0..2]=8'h10,8'h20,8'h30, mem[3]=HALT_OP; reset; run_i=1; ex_ready_i=1 with the PC model connected. Required: ir_o 10,20,30 with one pc_en_o pulse each, every 4 clocks; then halted_o=1; instr_cnt_o=3; no further pc_en_o.
- Handshake stall: ex_ready_i=0 for 5 cycles after ir_valid_o rises. Required: ir_o and ir_valid_o stable, pc_en_o=0 throughout; a single pulse after ready; count +1 only.
- Jump-to-zero: mem[2]=JMP0_OP. Required: on the advance after ir_o=8'h01 the PC returns to 0 and the fetch sequence restarts at mem[0]; instr_cnt_o keeps incrementing.
- Run drop: deassert run_i while in WAIT_EX. Required: the instruction completes with one pc_en_o pulse, then IDLE; reassert -> fetch resumes at the new pc_i.
- Async reset in WAIT_EX: pull rst_ni low mid-clock. Required: all outputs 0 immediately and no pc_en_o pulse; memory contents preserved, so re-run fetches the same program.
- Write collision: write mem[pc_i]=8'h55 in the FETCH cycle where old content is 8'h22. Required: ir_o=8'h22; the next fetch of that address returns 8'h55.
